// File: rtl/tff_pkg.sv
// -----------------------------------------------------------------------------
// tff_pkg
// Shared definitions for the reversible T-flip-flop bank sequencer:
//   - tff_op_e    : command opcodes carried on cmd_op
//   - tff_state_e : controller FSM states
//   - fredkin_mux : target output of a Fredkin (controlled-swap) gate
// -----------------------------------------------------------------------------
package tff_pkg;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_UP   = 2'b01,
        OP_DOWN = 2'b10,
        OP_LOAD = 2'b11
    } tff_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        LOAD = 2'b10,
        DONE = 2'b11
    } tff_state_e;

    // Fredkin gate (c, a, b) -> (c, c ? b : a, c ? a : b). Only the first
    // target rail is needed to build a T flip-flop; the complementary rail
    // is garbage and is therefore not produced.
    function automatic logic fredkin_mux(input logic c, input logic a, input logic b);
        logic o;
        if (c) begin
            o = b;
        end else begin
            o = a;
        end
        return o;
    endfunction

endpackage

// File: rtl/tff_rst_cell.sv
// -----------------------------------------------------------------------------
// tff_rst_cell
// One T flip-flop built from a Fredkin gate: control = t, inputs = (q, ~q),
// so the selected rail is ~q when t=1 and q when t=0.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears q
//   t     : toggle enable for this cycle
//   q     : stored bit
// -----------------------------------------------------------------------------
module tff_rst_cell
    import tff_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    output logic q
);

    logic q_q;
    logic q_d;

    // Next value through the Fredkin gate
    always_comb begin
        q_d = fredkin_mux(t, q_q, ~q_q);
    end

    // Storage bit with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/tff_bank_seq.sv
// -----------------------------------------------------------------------------
// tff_bank_seq
// Command-driven sequencer around a bank of WIDTH reversible T flip-flops.
// Commands: HOLD, UP/DOWN for cmd_len steps (one step per cycle), LOAD.
// Optional build macro TFF_BANK_SEQ_SAT_EN: counting saturates at all-ones
// (UP) or zero (DOWN) instead of wrapping; tc then flags the saturated step.
// Ports:
//   clk, rst_n         : clock (rising) and asynchronous active-low reset
//   cmd_valid/ready    : command handshake, ready only in IDLE
//   cmd_op/data/len    : opcode, LOAD target, UP/DOWN step count
//   abort              : ends a running UP/DOWN after the current step
//   q                  : bank state
//   t_vec              : toggle vector being applied to the bank this cycle
//   busy, done, tc     : status (busy in RUN/LOAD/DONE, done pulse, wrap pulse)
// -----------------------------------------------------------------------------
module tff_bank_seq
    import tff_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LW    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [LW-1:0]    cmd_len,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] t_vec,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    localparam logic [LW-1:0] LEN_ONE = LW'(1);

    tff_state_e       state_q, state_d;
    tff_op_e          op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [LW-1:0]    rem_q, rem_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             tc_q, tc_d;

    logic [WIDTH-1:0] bank_q;
    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;
    logic [WIDTH-1:0] t_vec_c;
    logic             wrap_c;
    logic             accept;

    // ready_q is only ever high in IDLE, so it alone qualifies acceptance
    assign accept = cmd_valid & ready_q;

    // Count toggles: bit i flips when all lower bits are 1 (UP) or 0 (DOWN)
    assign up_t[0] = 1'b1;
    assign dn_t[0] = 1'b1;
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_carry
        assign up_t[gi] = &bank_q[gi-1:0];
        assign dn_t[gi] = ~|bank_q[gi-1:0];
    end

    // Toggle vector and wrap detection for the current state
    always_comb begin
        t_vec_c = {WIDTH{1'b0}};
        wrap_c  = 1'b0;
        case (state_q)
            RUN: begin
                if (op_q == OP_UP) begin
                    wrap_c  = &bank_q;
                    t_vec_c = up_t;
                end else if (op_q == OP_DOWN) begin
                    wrap_c  = ~|bank_q;
                    t_vec_c = dn_t;
                end else begin
                    wrap_c  = 1'b0;
                    t_vec_c = {WIDTH{1'b0}};
                end
`ifdef TFF_BANK_SEQ_SAT_EN
                // Saturation: suppress the wrapping step so q holds
                if (wrap_c) begin
                    t_vec_c = {WIDTH{1'b0}};
                end else begin
                    t_vec_c = t_vec_c;
                end
`endif
            end
            LOAD: begin
                // Flip exactly the bits that differ from the target
                t_vec_c = bank_q ^ data_q;
            end
            default: begin
                t_vec_c = {WIDTH{1'b0}};
            end
        endcase
    end

    // FSM next state, command capture and step counter
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d   = tff_op_e'(cmd_op);
                    data_d = cmd_data;
                    rem_d  = cmd_len;
                    case (tff_op_e'(cmd_op))
                        OP_UP, OP_DOWN: begin
                            if (cmd_len == {LW{1'b0}}) begin
                                state_d = DONE;
                            end else begin
                                state_d = RUN;
                            end
                        end
                        OP_LOAD: state_d = LOAD;
                        default: state_d = DONE;
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                rem_d = rem_q - LEN_ONE;
                if (abort || (rem_q == LEN_ONE)) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            LOAD:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs registered from the next state
    always_comb begin
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        ready_d = (state_d == IDLE);
        tc_d    = wrap_c;
    end

    // Controller registers; ready stays low through reset and rises one edge later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_HOLD;
            data_q  <= {WIDTH{1'b0}};
            rem_q   <= {LW{1'b0}};
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            tc_q    <= tc_d;
        end
    end

    for (genvar gb = 0; gb < WIDTH; gb++) begin : g_bank
        tff_rst_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .t     (t_vec_c[gb]),
            .q     (bank_q[gb])
        );
    end

    assign q         = bank_q;
    assign t_vec     = t_vec_c;
    assign busy      = busy_q;
    assign done      = done_q;
    assign tc        = tc_q;
    assign cmd_ready = ready_q;

endmodule

// File: tb/tb_tff_bank_seq.sv
// -----------------------------------------------------------------------------
// tb_tff_bank_seq
// Scoreboard bench: each issued command pushes the per-cycle response it
// should produce while busy (q, t_vec, tc, done); a monitor on the falling
// edge pops and compares one entry per busy cycle.
// -----------------------------------------------------------------------------
module tb_tff_bank_seq;

    localparam int W    = 4;
    localparam int L    = 8;
    localparam int MASK = (1 << W) - 1;

`ifdef TFF_BANK_SEQ_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        int q;
        int tv;
        int tc;
        int done;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'b00;
    logic [W-1:0] cmd_data = '0;
    logic [L-1:0] cmd_len = '0;
    logic         abort = 1'b0;
    logic [W-1:0] q;
    logic [W-1:0] t_vec;
    logic         busy;
    logic         done;
    logic         tc;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   mq = 0;
    bit   chk_ready = 1'b0;

    tff_bank_seq #(.WIDTH(W), .LW(L)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_len   (cmd_len),
        .abort     (abort),
        .q         (q),
        .t_vec     (t_vec),
        .busy      (busy),
        .done      (done),
        .tc        (tc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares every busy cycle against the scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_q", int'(q), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_tc", int'(tc), 0);
            chk("rst_tvec", int'(t_vec), 0);
            chk("rst_ready", int'(cmd_ready), 0);
        end else if (busy) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", int'(busy), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("q", int'(q), e.q);
                chk("t_vec", int'(t_vec), e.tv);
                chk("tc", int'(tc), e.tc);
                chk("done", int'(done), e.done);
            end
        end else begin
            chk("idle_done", int'(done), 0);
            chk("idle_tc", int'(tc), 0);
            chk("idle_tvec", int'(t_vec), 0);
        end
        if (rst_n && chk_ready) begin
            chk("ready", int'(cmd_ready), int'(!busy));
        end
    end

    // Reference model: expected busy-cycle trace of one command
    task automatic push_cmd(input int op, input int data, input int len, input int k);
        int   qc;
        int   nq;
        int   s;
        int   tcp;
        bit   wrap;
        exp_t e;
        qc = mq;
        if (op == 3) begin
            e = '{q: qc, tv: qc ^ data, tc: 0, done: 0}; sb.push_back(e);
            e = '{q: data, tv: 0, tc: 0, done: 1};       sb.push_back(e);
            mq = data;
        end else if (op == 0) begin
            e = '{q: qc, tv: 0, tc: 0, done: 1}; sb.push_back(e);
        end else begin
            s = len;
            if (k > 0 && k < s) s = k;
            tcp = 0;
            for (int j = 0; j < s; j++) begin
                if (op == 1) begin
                    wrap = (qc == MASK);
                    nq   = (qc + 1) & MASK;
                end else begin
                    wrap = (qc == 0);
                    nq   = (qc - 1) & MASK;
                end
                if (SAT && wrap) nq = qc;
                e = '{q: qc, tv: qc ^ nq, tc: tcp, done: 0}; sb.push_back(e);
                tcp = int'(wrap);
                qc  = nq;
            end
            e = '{q: qc, tv: 0, tc: tcp, done: 1}; sb.push_back(e);
            mq = qc;
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!cmd_ready && n < 300) begin
            cmd_op   = 2'($urandom);
            cmd_data = W'($urandom);
            cmd_len  = L'($urandom);
            @(posedge clk); #1;
            n++;
        end
        chk("ready_wait", int'(cmd_ready), 1);
    endtask

    task automatic issue(input int op, input int data, input int len, input int k);
        wait_ready();
        push_cmd(op, data, len, k);
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        cmd_data  = W'(data);
        cmd_len   = L'(len);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_data  = W'($urandom);
        cmd_len   = L'($urandom);
        if (k > 0) begin
            repeat (k - 1) begin
                @(posedge clk); #1;
            end
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
        end
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        #0;
        chk("ready_at_release", int'(cmd_ready), 0);
        @(posedge clk); #1;
        chk("ready_after_release", int'(cmd_ready), 1);
        chk_ready = 1'b1;
    endtask

    task automatic random_cmds(input int n);
        int op, data, len, k;
        for (int i = 0; i < n; i++) begin
            op   = int'($urandom_range(0, 3));
            data = int'($urandom_range(0, MASK));
            len  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                               : int'($urandom_range(0, 20));
            k    = 0;
            if ($urandom_range(0, 2) == 0) begin
                k = (op == 1 || op == 2) ? int'($urandom_range(1, len + 2))
                                         : int'($urandom_range(1, 2));
            end
            issue(op, data, len, k);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        release_reset();
        mq = 0;

        issue(1, 0, 5, 0);        // UP 5 from 0
        issue(3, 3, 0, 0);        // LOAD 3
        issue(3, 14, 0, 0);       // LOAD E from 3: t_vec D
        issue(1, 0, 3, 0);        // UP 3 from E: wraps (or saturates)
        issue(3, 8, 0, 0);
        issue(2, 0, 200, 3);      // DOWN 200 aborted on 3rd RUN cycle
        issue(0, 5, 7, 1);        // HOLD, abort outside RUN
        issue(1, 0, 0, 0);        // UP with len 0
        issue(2, 0, 0, 2);        // DOWN with len 0

        random_cmds(80);

        // Reset in the middle of a long UP
        issue(1, 0, 10, 0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        chk_ready = 1'b0;
        #1;
        chk("midrst_q", int'(q), 0);
        chk("midrst_ready", int'(cmd_ready), 0);
        chk("midrst_done", int'(done), 0);
        sb.delete();
        mq = 0;
        repeat (3) @(posedge clk);
        #1;
        release_reset();

        random_cmds(40);

        wait_ready();
        repeat (2) @(posedge clk);
        #1;
        chk("sb_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
